// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared widths and FSM state encoding for the ADC waveform
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

    localparam int LEN_W = 12;
    localparam int CNT_W = 8;
    localparam int GAP_W = 22;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUF = 3'd1,
        CAPTURE  = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/adc_waveform_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_waveform_sequencer_if
// Description : Run-control, config and capture-marker bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_waveform_sequencer_if #(
    parameter int LEN_W = adc_seq_pkg::LEN_W,
    parameter int CNT_W = adc_seq_pkg::CNT_W,
    parameter int GAP_W = adc_seq_pkg::GAP_W
);
    logic             enable;
    logic             trig;
    logic [CNT_W-1:0] num_waveforms;
    logic [LEN_W-1:0] waveform_length;
    logic [GAP_W-1:0] waveform_gap;
    logic             buf_ready;
    logic             capture_en;
    logic             wf_start;
    logic             wf_end;
    logic [CNT_W-1:0] wf_index;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             trig_ignored;

    modport master (
        output enable, trig, num_waveforms, waveform_length, waveform_gap, buf_ready,
        input  capture_en, wf_start, wf_end, wf_index, busy, done, aborted, trig_ignored
    );

    modport slave (
        input  enable, trig, num_waveforms, waveform_length, waveform_gap, buf_ready,
        output capture_en, wf_start, wf_end, wf_index, busy, done, aborted, trig_ignored
    );
endinterface
`default_nettype wire

// File: rtl/adc_seq_down_cntr.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_down_cntr
// Description : Loadable down-counter that saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_down_cntr #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] load_val,
    output logic      [WIDTH-1:0] count,
    output logic                  at_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count   = r_count;
    assign at_zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/adc_waveform_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_waveform_sequencer
// Description : Captures a programmed burst of fixed-length waveforms per
//               trigger, gated on downstream buffer space.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_waveform_sequencer #(
    parameter int LEN_W = adc_seq_pkg::LEN_W,
    parameter int CNT_W = adc_seq_pkg::CNT_W,
    parameter int GAP_W = adc_seq_pkg::GAP_W
) (
    input wire logic                clk,
    input wire logic                rst_n,
    adc_waveform_sequencer_if.slave bus
);
    import adc_seq_pkg::*;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [LEN_W-1:0] r_len;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;
    logic             r_cap, r_start, r_end, r_busy, r_done, r_aborted, r_ign;
    logic             w_cap_nxt, w_start_nxt, w_end_nxt, w_done_nxt, w_abort_nxt, w_ign_nxt;
    logic             w_latch;
    logic             w_smp_load, w_smp_en, w_smp_zero;
    logic [LEN_W-1:0] w_smp_cnt;
    logic             w_gap_load, w_gap_en, w_gap_zero;
    logic [GAP_W-1:0] w_gap_cnt;

    adc_seq_down_cntr #(.WIDTH(LEN_W)) u_smp_cntr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_smp_load),
        .enable   (w_smp_en),
        .load_val (r_len - LEN_W'(1)),
        .count    (w_smp_cnt),
        .at_zero  (w_smp_zero)
    );

    adc_seq_down_cntr #(.WIDTH(GAP_W)) u_gap_cntr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_gap_load),
        .enable   (w_gap_en),
        .load_val (r_gap),
        .count    (w_gap_cnt),
        .at_zero  (w_gap_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cap_nxt   = 1'b0;
        w_start_nxt = 1'b0;
        w_end_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_ign_nxt   = bus.trig && (r_state != IDLE);
        w_latch     = 1'b0;
        w_smp_load  = 1'b0;
        w_smp_en    = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_en    = 1'b0;

        // Losing enable overrides everything, including a pending last sample.
        if ((r_state != IDLE) && !bus.enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_abort_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.trig) begin
                        if (bus.enable && (bus.num_waveforms != '0) && (bus.waveform_length != '0)) begin
                            w_latch     = 1'b1;
                            w_idx_nxt   = '0;
                            w_state_nxt = WAIT_BUF;
                        end else begin
                            w_ign_nxt = 1'b1;
                        end
                    end
                end
                WAIT_BUF: begin
                    if (bus.buf_ready) begin
                        w_state_nxt = CAPTURE;
                        w_smp_load  = 1'b1;
                        w_cap_nxt   = 1'b1;
                        w_start_nxt = 1'b1;
                        w_end_nxt   = (r_len == LEN_W'(1));
                    end
                end
                CAPTURE: begin
                    if (w_smp_zero) begin
                        if (r_idx == (r_num - CNT_W'(1))) begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end else if (r_gap == '0) begin
                            w_state_nxt = WAIT_BUF;
                            w_idx_nxt   = r_idx + CNT_W'(1);
                        end else begin
                            w_state_nxt = GAP;
                            w_gap_load  = 1'b1;
                        end
                    end else begin
                        w_cap_nxt = 1'b1;
                        w_smp_en  = 1'b1;
                        w_end_nxt = (w_smp_cnt == LEN_W'(1));
                    end
                end
                GAP: begin
                    // Counter holds gap..1 across the gap cycles; the exit edge takes it to 0.
                    w_gap_en = 1'b1;
                    if ((w_gap_cnt == GAP_W'(1)) || w_gap_zero) begin
                        w_state_nxt = WAIT_BUF;
                        w_idx_nxt   = r_idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_num     <= '0;
            r_len     <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_cap     <= 1'b0;
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_ign     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cap     <= w_cap_nxt;
            r_start   <= w_start_nxt;
            r_end     <= w_end_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
            r_aborted <= w_abort_nxt;
            r_ign     <= w_ign_nxt;
            if (w_latch) begin
                r_num <= bus.num_waveforms;
                r_len <= bus.waveform_length;
                r_gap <= bus.waveform_gap;
            end
        end
    end

    assign bus.capture_en   = r_cap;
    assign bus.wf_start     = r_start;
    assign bus.wf_end       = r_end;
    assign bus.wf_index     = r_idx;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.trig_ignored = r_ign;
endmodule
`default_nettype wire

// File: tb/tb_adc_waveform_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_waveform_sequencer
// Description : Randomized and directed bench with a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_waveform_sequencer;
    localparam int LEN_W = 12;
    localparam int CNT_W = 8;
    localparam int GAP_W = 22;
    localparam int OW    = 7 + CNT_W;
    localparam int MAXC  = 4200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Per-cycle stimulus script
    bit s_trig [MAXC+2];
    bit s_en   [MAXC+2];
    bit s_br   [MAXC+2];
    int s_n    [MAXC+2];
    int s_l    [MAXC+2];
    int s_g    [MAXC+2];

    // Per-cycle expected outputs
    bit e_cap [MAXC+2];
    bit e_st  [MAXC+2];
    bit e_end [MAXC+2];
    bit e_busy[MAXC+2];
    bit e_done[MAXC+2];
    bit e_ab  [MAXC+2];
    bit e_ign [MAXC+2];
    int e_idx [MAXC+2];

    adc_waveform_sequencer_if #(.LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    adc_waveform_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] dut_vec();
        return {bus.capture_en, bus.wf_start, bus.wf_end, bus.busy, bus.done,
                bus.aborted, bus.trig_ignored, bus.wf_index};
    endfunction

    function automatic logic [OW-1:0] exp_vec(input int x);
        return {e_cap[x], e_st[x], e_end[x], e_busy[x], e_done[x], e_ab[x], e_ign[x], CNT_W'(e_idx[x])};
    endfunction

    task automatic mark(input int x, input bit cap, input bit st, input bit en, input int k, input bit dn);
        e_cap[x] = cap; e_st[x] = st; e_end[x] = en; e_busy[x] = 1'b1; e_done[x] = dn; e_idx[x] = k;
    endtask

    // Common bookkeeping for any cycle spent inside a sequence; returns 1 on abort.
    function automatic bit seq_cycle(input int x);
        if (s_trig[x]) e_ign[x+1] = 1'b1;
        if (!s_en[x]) begin
            e_ab[x+1] = 1'b1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Walk the script as a timeline of bursts: wait for buffer, L samples, gap, ..., done.
    task automatic build_model(input int T);
        int x, k, nn, ll, gg;
        bit stop, got;
        for (int i = 0; i < MAXC + 2; i++) begin
            e_cap[i] = 0; e_st[i] = 0; e_end[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_ab[i] = 0; e_ign[i] = 0; e_idx[i] = 0;
        end
        x = 0;
        while (x < T) begin
            if (s_trig[x] && s_en[x] && s_n[x] != 0 && s_l[x] != 0) begin
                nn = s_n[x]; ll = s_l[x]; gg = s_g[x];
                x++;
                stop = 0;
                for (k = 0; k < nn && !stop && x < T; k++) begin
                    got = 0;
                    while (!got && !stop && x < T) begin
                        mark(x, 0, 0, 0, k, 0);
                        if (seq_cycle(x)) stop = 1;
                        else if (s_br[x]) got = 1;
                        x++;
                    end
                    for (int s = 0; s < ll && !stop && x < T; s++) begin
                        mark(x, 1, s == 0, s == ll - 1, k, 0);
                        if (seq_cycle(x)) stop = 1;
                        x++;
                    end
                    if (!stop && x < T) begin
                        if (k == nn - 1) begin
                            mark(x, 0, 0, 0, k, 1);
                            if (seq_cycle(x)) stop = 1;
                            x++;
                        end else begin
                            for (int g = 0; g < gg && !stop && x < T; g++) begin
                                mark(x, 0, 0, 0, k, 0);
                                if (seq_cycle(x)) stop = 1;
                                x++;
                            end
                        end
                    end
                end
            end else begin
                if (s_trig[x]) e_ign[x+1] = 1'b1;
                x++;
            end
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC + 2; i++) begin
            s_trig[i] = 0; s_en[i] = 1; s_br[i] = 1;
            s_n[i] = int'($urandom_range(0, 255));
            s_l[i] = int'($urandom_range(0, 4095));
            s_g[i] = int'($urandom_range(0, (1 << GAP_W) - 1));
        end
    endtask

    task automatic set_trig(input int x, input int n, input int l, input int g);
        s_trig[x] = 1; s_n[x] = n; s_l[x] = l; s_g[x] = g;
    endtask

    task automatic drive(input int x);
        bus.trig            = s_trig[x];
        bus.enable          = s_en[x];
        bus.buf_ready       = s_br[x];
        bus.num_waveforms   = CNT_W'(s_n[x]);
        bus.waveform_length = LEN_W'(s_l[x]);
        bus.waveform_gap    = GAP_W'(s_g[x]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.trig = 0; bus.enable = 1; bus.buf_ready = 1;
        bus.num_waveforms = '0; bus.waveform_length = '0; bus.waveform_gap = '0;
        #1 check_eq("reset", dut_vec(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_scn(input int id, input int T, input int rst_at);
        build_model(T);
        apply_reset();
        for (int x = 0; x < T; x++) begin
            @(posedge clk);
            #1 drive(x);
            @(negedge clk);
            check_eq($sformatf("s%0d_c%0d", id, x), dut_vec(), exp_vec(x));
            if (x == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_eq($sformatf("s%0d_async_rst", id), dut_vec(), '0);
                break;
            end
        end
    endtask

    initial begin
        // Three waveforms, L=4, gap=5
        clear_stim(); set_trig(2, 3, 4, 5);
        run_scn(1, 45, -1);
        // Single-sample waveforms, no gap
        clear_stim(); set_trig(2, 2, 1, 0);
        run_scn(2, 15, -1);
        // Buffer stall in the second WAIT_BUF
        clear_stim(); set_trig(2, 2, 8, 2);
        for (int i = 14; i < 24; i++) s_br[i] = 0;
        run_scn(3, 45, -1);
        // Trigs while busy and with zero count/length
        clear_stim(); set_trig(2, 3, 4, 6);
        set_trig(9, 0, 4, 1); set_trig(11, 2, 3, 1);
        set_trig(35, 0, 5, 1); set_trig(38, 1, 0, 0);
        run_scn(4, 45, -1);
        // Enable dropped on third sample of waveform 1, then restart
        clear_stim(); set_trig(2, 4, 8, 3);
        s_en[18] = 0;
        set_trig(22, 2, 2, 1);
        run_scn(5, 40, -1);
        // Full-width gap, aborted partway through
        clear_stim(); set_trig(2, 2, 2, (1 << GAP_W) - 1);
        s_en[200] = 0;
        run_scn(6, 220, -1);
        // Longest waveform
        clear_stim(); set_trig(2, 1, 4095, 0);
        run_scn(7, 4110, -1);
        // Most waveforms
        clear_stim(); set_trig(2, 255, 1, 0);
        run_scn(8, 530, -1);
        // Asynchronous reset mid-capture, then a fresh sequence with new config
        clear_stim(); set_trig(2, 3, 4, 5);
        run_scn(9, 30, 6);
        clear_stim(); set_trig(2, 2, 3, 1);
        run_scn(10, 20, -1);
        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            clear_stim();
            for (int i = 0; i < 300; i++) begin
                s_trig[i] = ($urandom_range(0, 14) == 0);
                s_en[i]   = ($urandom_range(0, 59) != 0);
                s_br[i]   = ($urandom_range(0, 3) != 0);
                s_n[i]    = int'($urandom_range(0, 4));
                s_l[i]    = int'($urandom_range(0, 9));
                s_g[i]    = int'($urandom_range(0, 5));
            end
            run_scn(100 + r, 300, -1);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
